// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the matmul scheduler
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam int JOBS_WIDTH = 16;

endpackage

// File: rtl/matmul_sched_if.sv
// rtl/matmul_sched_if.sv - requester and engine handshake bundle of the scheduler
interface matmul_sched_if
  import matmul_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    ack;
  logic                  ack_err;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  eng_start;
  logic                  eng_done;
  logic                  eng_abort;
  logic [JOBS_WIDTH-1:0] jobs_done;

  // master is the scheduler, slave is the requester/engine fabric
  modport master (
    input  req, eng_done,
    output ack, ack_err, grant_valid, grant_id, eng_start, eng_abort, jobs_done
  );

  modport slave (
    output req, eng_done,
    input  ack, ack_err, grant_valid, grant_id, eng_start, eng_abort, jobs_done
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set bit at or above ptr, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  localparam int SW = W + 1;

  logic [SW-1:0] slot;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    index = '0;
    slot  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      slot = {1'b0, ptr} + SW'(i);
      if (slot >= SW'(N)) begin
        slot = slot - SW'(N);
      end
      if (mask[slot[W-1:0]]) begin
        found = 1'b1;
        index = slot[W-1:0];
      end
    end
  end

endmodule

// File: rtl/matmul_sched.sv
// rtl/matmul_sched.sv - round-robin scheduler sharing one matmul engine among requesters
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  localparam int ID_WIDTH  = $clog2(NUM_REQ),
  localparam int TMO_WIDTH = $clog2(TIMEOUT + 1)
) (
  input logic            clock,
  input logic            reset,
  matmul_sched_if.master bus
);

  sched_state_t state, state_nxt;

  logic [ID_WIDTH-1:0]   gid;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [NUM_REQ-1:0]    mask_last;
  logic [NUM_REQ-1:0]    cand;
  logic                  done_q;
  logic                  err_q;
  logic [TMO_WIDTH-1:0]  wd_cnt;
  logic [JOBS_WIDTH-1:0] jobs;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  done_edge;
  logic                  wd_expire;

  assign cand      = bus.req & ~mask_last;
  assign done_edge = bus.eng_done & ~done_q;
  assign wd_expire = (wd_cnt == TMO_WIDTH'(TIMEOUT - 1));

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_WIDTH)
  ) u_pick (
    .mask  (cand),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (done_edge || wd_expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // eng_abort must see the same-cycle done edge so that a completion wins the tie.
  always_comb begin
    bus.ack         = '0;
    bus.ack_err     = 1'b0;
    bus.grant_valid = 1'b0;
    bus.grant_id    = '0;
    bus.eng_start   = 1'b0;
    bus.eng_abort   = 1'b0;
    case (state)
      START: begin
        bus.grant_valid = 1'b1;
        bus.grant_id    = gid;
        bus.eng_start   = 1'b1;
      end
      WAIT: begin
        bus.grant_valid = 1'b1;
        bus.grant_id    = gid;
        bus.eng_abort   = wd_expire & ~done_edge;
      end
      RESP: begin
        bus.grant_valid = 1'b1;
        bus.grant_id    = gid;
        bus.ack[gid]    = 1'b1;
        bus.ack_err     = err_q;
      end
      default: ;
    endcase
  end

  assign bus.jobs_done = jobs;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gid       <= '0;
      rr_ptr    <= '0;
      mask_last <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wd_cnt    <= '0;
      jobs      <= '0;
    end else begin
      done_q <= bus.eng_done;
      case (state)
        IDLE: begin
          mask_last <= '0;
          if (pick_found) begin
            gid <= pick_idx;
          end
        end
        START: begin
          wd_cnt <= '0;
        end
        WAIT: begin
          if (done_edge) begin
            err_q <= 1'b0;
            jobs  <= jobs + 1'b1;
          end else if (wd_expire) begin
            err_q <= 1'b1;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          rr_ptr         <= (gid == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
          mask_last      <= '0;
          mask_last[gid] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
